// File: rtl/dds_pkg.sv
// Shared definitions for the DDS frequency-sweep controller: default widths,
// sweep mode encodings and the controller state / direction enums.
package dds_pkg;

    localparam int FCW_W_DEF   = 10;
    localparam int DWELL_W_DEF = 16;

    localparam logic [1:0] MODE_UP_ONESHOT = 2'd0;
    localparam logic [1:0] MODE_UP_REPEAT  = 2'd1;
    localparam logic [1:0] MODE_TRIANGLE   = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DWELL = 2'd2
    } state_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

endpackage

// File: rtl/dds_sweep_controller_dwell_timer.sv
// Loadable down-counter that times how long each FCW value is held.
// expire is high while the count is zero; near_expire flags a count of one so
// the controller can register pulses that must line up with the final cycle.
module dwell_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expire,
    output logic         near_expire
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Reload on request, otherwise count down and park at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != {W{1'b0}}) begin
            cnt_d = cnt_q - {{(W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= {W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire      = (cnt_q == {W{1'b0}});
    assign near_expire = (cnt_q == {{(W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/dds_sweep_controller.sv
// Frequency-sweep sequencer: steps the accumulator FCW from start to stop
// (one-shot, repeating ramp or triangle), holding each value dwell+1 cycles.
module dds_sweep_controller
    import dds_pkg::*;
#(
    parameter int FCW_W   = FCW_W_DEF,
    parameter int DWELL_W = DWELL_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [FCW_W-1:0]   cfg_fcw_start,
    input  logic [FCW_W-1:0]   cfg_fcw_stop,
    input  logic [FCW_W-1:0]   cfg_fcw_step,
    input  logic [DWELL_W-1:0] cfg_dwell,
    input  logic [1:0]         cfg_mode,
    input  logic               start,
    input  logic               abort,
    output logic               busy,
    output logic [FCW_W-1:0]   fcw,
    output logic               fcw_valid,
    output logic               phase_clr,
    output logic               sweep_done
);

    state_e             state_q, state_d;
    dir_e               dir_q, dir_d;
    logic [FCW_W-1:0]   fcw_q, fcw_d;
    logic               busy_q, busy_d, fcw_valid_q, fcw_valid_d;
    logic               phase_clr_q, phase_clr_d, sweep_done_q, sweep_done_d;
    logic [FCW_W-1:0]   cfg_start_q, cfg_start_d, cfg_stop_q, cfg_stop_d, cfg_step_q, cfg_step_d;
    logic [DWELL_W-1:0] cfg_dwell_q, cfg_dwell_d;
    logic [1:0]         cfg_mode_q, cfg_mode_d;

    // Effective config: a config offered in IDLE is already in force for a
    // start arriving in the same cycle.
    logic               capture_s;
    logic [FCW_W-1:0]   eff_start_s, eff_stop_s, eff_step_s;
    logic [DWELL_W-1:0] eff_dwell_s;
    logic [1:0]         eff_mode_s;
    logic               tri_s, rpt_s, period_end_s, next_zero_s;
    logic               tmr_load_s, tmr_expire_s, tmr_near_s;
    logic [FCW_W:0]     up_sum_s, dn_diff_s;
    logic               up_clamp_s, dn_clamp_s;
    logic [FCW_W-1:0]   up_fcw_s, dn_fcw_s;

    // True when value f/direction d is the last value of a sweep period.
    function automatic logic at_period_end(input logic [FCW_W-1:0] f, input dir_e d,
                                           input logic [FCW_W-1:0] s, input logic [FCW_W-1:0] e,
                                           input logic [1:0] m);
        logic res;
        if (s >= e) begin
            res = 1'b1;
        end else if (m == MODE_TRIANGLE) begin
            res = (d == DIR_DOWN) && (f == s);
        end else begin
            res = (f == e);
        end
        return res;
    endfunction

    assign capture_s = (state_q == ST_IDLE) && cfg_valid;
    assign cfg_ready = (state_q == ST_IDLE);

    // Config register next values and the effective config seen this cycle.
    always_comb begin
        cfg_start_d = capture_s ? cfg_fcw_start : cfg_start_q;
        cfg_stop_d  = capture_s ? cfg_fcw_stop  : cfg_stop_q;
        cfg_step_d  = capture_s ? cfg_fcw_step  : cfg_step_q;
        cfg_dwell_d = capture_s ? cfg_dwell     : cfg_dwell_q;
        cfg_mode_d  = capture_s ? cfg_mode      : cfg_mode_q;
        eff_start_s = cfg_start_d;
        eff_stop_s  = cfg_stop_d;
        eff_dwell_s = cfg_dwell_d;
        eff_mode_s  = cfg_mode_d;
        if (cfg_step_d == {FCW_W{1'b0}}) begin
            eff_step_s = {{(FCW_W-1){1'b0}}, 1'b1};
        end else begin
            eff_step_s = cfg_step_d;
        end
        tri_s = (eff_mode_s == MODE_TRIANGLE);
        rpt_s = (eff_mode_s == MODE_UP_REPEAT);
    end

    // Step datapath: one extra bit so carries/borrows clamp instead of wrapping.
    always_comb begin
        up_sum_s   = {1'b0, fcw_q} + {1'b0, eff_step_s};
        dn_diff_s  = {1'b0, fcw_q} - {1'b0, eff_step_s};
        up_clamp_s = (up_sum_s >= {1'b0, eff_stop_s});
        dn_clamp_s = dn_diff_s[FCW_W] || (dn_diff_s[FCW_W-1:0] <= eff_start_s);
        up_fcw_s   = up_clamp_s ? eff_stop_s  : up_sum_s[FCW_W-1:0];
        dn_fcw_s   = dn_clamp_s ? eff_start_s : dn_diff_s[FCW_W-1:0];
        period_end_s = at_period_end(fcw_q, dir_q, eff_start_s, eff_stop_s, eff_mode_s);
    end

    // Sweep FSM: next state, next FCW/direction and registered output pulses.
    always_comb begin
        state_d     = state_q;
        dir_d       = dir_q;
        fcw_d       = fcw_q;
        busy_d      = busy_q;
        fcw_valid_d = fcw_valid_q;
        phase_clr_d = 1'b0;
        tmr_load_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    state_d     = ST_LOAD;
                    dir_d       = DIR_UP;
                    fcw_d       = eff_start_s;
                    busy_d      = 1'b1;
                    fcw_valid_d = 1'b1;
                    phase_clr_d = 1'b1;
                    tmr_load_s  = 1'b1;
                end else begin
                    state_d     = ST_IDLE;
                    dir_d       = DIR_UP;
                    fcw_d       = {FCW_W{1'b0}};
                    busy_d      = 1'b0;
                    fcw_valid_d = 1'b0;
                end
            end
            ST_LOAD, ST_DWELL: begin
                if (abort) begin
                    state_d     = ST_IDLE;
                    dir_d       = DIR_UP;
                    fcw_d       = {FCW_W{1'b0}};
                    busy_d      = 1'b0;
                    fcw_valid_d = 1'b0;
                end else begin
                    state_d = ST_DWELL;
                    if (!tmr_expire_s) begin
                        fcw_d = fcw_q;
                    end else if (period_end_s && rpt_s) begin
                        fcw_d       = eff_start_s;
                        dir_d       = DIR_UP;
                        phase_clr_d = 1'b1;
                        tmr_load_s  = 1'b1;
                    end else if (period_end_s && tri_s) begin
                        // Triangle restarts its up leg from start+step; a
                        // single-point sweep simply stays on start.
                        tmr_load_s = 1'b1;
                        if (eff_start_s >= eff_stop_s) begin
                            fcw_d = eff_start_s;
                            dir_d = DIR_UP;
                        end else begin
                            fcw_d = up_fcw_s;
                            dir_d = up_clamp_s ? DIR_DOWN : DIR_UP;
                        end
                    end else if (period_end_s) begin
                        state_d     = ST_IDLE;
                        dir_d       = DIR_UP;
                        fcw_d       = {FCW_W{1'b0}};
                        busy_d      = 1'b0;
                        fcw_valid_d = 1'b0;
                    end else if (dir_q == DIR_UP) begin
                        fcw_d      = up_fcw_s;
                        dir_d      = (up_clamp_s && tri_s) ? DIR_DOWN : DIR_UP;
                        tmr_load_s = 1'b1;
                    end else begin
                        fcw_d      = dn_fcw_s;
                        dir_d      = DIR_DOWN;
                        tmr_load_s = 1'b1;
                    end
                end
            end
            default: begin
                state_d     = ST_IDLE;
                dir_d       = DIR_UP;
                fcw_d       = {FCW_W{1'b0}};
                busy_d      = 1'b0;
                fcw_valid_d = 1'b0;
            end
        endcase
        // sweep_done is registered, so look one cycle ahead: it must be high
        // in the cycle where the final value's dwell counter reads zero.
        next_zero_s  = tmr_load_s ? (eff_dwell_s == {DWELL_W{1'b0}})
                                  : (tmr_expire_s || tmr_near_s);
        sweep_done_d = busy_d && next_zero_s &&
                       at_period_end(fcw_d, dir_d, eff_start_s, eff_stop_s, eff_mode_s);
    end

    // State, config and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            dir_q        <= DIR_UP;
            fcw_q        <= {FCW_W{1'b0}};
            busy_q       <= 1'b0;
            fcw_valid_q  <= 1'b0;
            phase_clr_q  <= 1'b0;
            sweep_done_q <= 1'b0;
            cfg_start_q  <= {FCW_W{1'b0}};
            cfg_stop_q   <= {FCW_W{1'b0}};
            cfg_step_q   <= {FCW_W{1'b0}};
            cfg_dwell_q  <= {DWELL_W{1'b0}};
            cfg_mode_q   <= 2'd0;
        end else begin
            state_q      <= state_d;
            dir_q        <= dir_d;
            fcw_q        <= fcw_d;
            busy_q       <= busy_d;
            fcw_valid_q  <= fcw_valid_d;
            phase_clr_q  <= phase_clr_d;
            sweep_done_q <= sweep_done_d;
            cfg_start_q  <= cfg_start_d;
            cfg_stop_q   <= cfg_stop_d;
            cfg_step_q   <= cfg_step_d;
            cfg_dwell_q  <= cfg_dwell_d;
            cfg_mode_q   <= cfg_mode_d;
        end
    end

    dwell_timer #(.W(DWELL_W)) u_dwell_timer (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (tmr_load_s),
        .load_val    (eff_dwell_s),
        .expire      (tmr_expire_s),
        .near_expire (tmr_near_s)
    );

    assign busy       = busy_q;
    assign fcw        = fcw_q;
    assign fcw_valid  = fcw_valid_q;
    assign phase_clr  = phase_clr_q;
    assign sweep_done = sweep_done_q;

endmodule

// File: tb/tb_dds_sweep_controller.sv
// Self-checking bench for dds_sweep_controller: a table of sweep configurations
// with their expected FCW value lists, expanded into a per-cycle scoreboard,
// plus hand-written handshake, abort and reset sequences.
module tb_dds_sweep_controller;

    logic        clk = 1'b0;
    logic        rst_n, cfg_valid, cfg_ready, start, abort;
    logic [9:0]  cfg_fcw_start, cfg_fcw_stop, cfg_fcw_step, fcw;
    logic [15:0] cfg_dwell;
    logic [1:0]  cfg_mode;
    logic        busy, fcw_valid, phase_clr, sweep_done;

    int n_checks = 0;
    int n_pass   = 0;

    always #500 clk = ~clk;

    dds_sweep_controller #(.FCW_W(10), .DWELL_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_fcw_start(cfg_fcw_start), .cfg_fcw_stop(cfg_fcw_stop),
        .cfg_fcw_step(cfg_fcw_step), .cfg_dwell(cfg_dwell), .cfg_mode(cfg_mode),
        .start(start), .abort(abort), .busy(busy), .fcw(fcw),
        .fcw_valid(fcw_valid), .phase_clr(phase_clr), .sweep_done(sweep_done)
    );

    typedef struct packed {
        logic       rdy;
        logic       busy;
        logic       fv;
        logic [9:0] fcw;
        logic       pclr;
        logic       done;
    } obs_t;

    typedef struct {
        int        st, sp, stp, dw, md, n;
        int        vals [10];
        bit  [9:0] pclr_m;
        bit  [9:0] done_m;
        bit        ends_idle;
    } vec_t;

    obs_t sb[$];
    vec_t tbl[7];

    task automatic push_rec(input int f, input bit pclr, input bit done);
        obs_t e;
        e.rdy = 1'b0; e.busy = 1'b1; e.fv = 1'b1; e.fcw = f[9:0];
        e.pclr = pclr; e.done = done;
        sb.push_back(e);
    endtask

    task automatic push_idle();
        obs_t e;
        e = '0;
        e.rdy = 1'b1;
        sb.push_back(e);
    endtask

    task automatic push_vec(input vec_t v);
        for (int k = 0; k < v.n; k++) begin
            for (int c = 0; c <= v.dw; c++) begin
                push_rec(v.vals[k], (c == 0) && v.pclr_m[k], (c == v.dw) && v.done_m[k]);
            end
        end
        push_idle();
    endtask

    // Pop one expected record and compare it with the DUT outputs (at negedge).
    task automatic check_pop(input string nm);
        obs_t e, a;
        @(negedge clk);
        a = {cfg_ready, busy, fcw_valid, fcw, phase_clr, sweep_done};
        n_checks++;
        if (sb.size() == 0) begin
            $display("FAIL %s: scoreboard empty, got rdy/busy/fv=%b%b%b fcw=%0d", nm, a.rdy, a.busy, a.fv, a.fcw);
        end else begin
            e = sb.pop_front();
            if (a === e) begin
                n_pass++;
            end else begin
                $display("FAIL %s @%0t: got rdy=%b busy=%b fv=%b fcw=%0d pclr=%b done=%b, expected rdy=%b busy=%b fv=%b fcw=%0d pclr=%b done=%b",
                         nm, $time, a.rdy, a.busy, a.fv, a.fcw, a.pclr, a.done,
                         e.rdy, e.busy, e.fv, e.fcw, e.pclr, e.done);
            end
        end
    endtask

    // Drain the scoreboard; kind 1 aborts, kind 2 resets in the cycle before
    // the final (idle) record is checked.
    task automatic drain(input int kind, input string nm);
        int guard = 0;
        while (sb.size() > 0 && guard < 200) begin
            check_pop(nm);
            if (sb.size() == 1 && kind == 1) abort = 1'b1;
            if (sb.size() == 1 && kind == 2) rst_n = 1'b0;
            @(posedge clk); #1;
            abort = 1'b0;
            rst_n = 1'b1;
            guard++;
        end
        if (sb.size() > 0) begin
            n_checks++;
            $display("FAIL %s: %0d expected records never checked", nm, sb.size());
            sb.delete();
        end
    endtask

    task automatic set_cfg(input int st, input int sp, input int stp, input int dw, input int md);
        cfg_fcw_start = st[9:0]; cfg_fcw_stop = sp[9:0]; cfg_fcw_step = stp[9:0];
        cfg_dwell = dw[15:0]; cfg_mode = md[1:0];
    endtask

    initial begin
        tbl[0] = '{st:16, sp:64, stp:16, dw:2, md:0, n:4, vals:'{16,32,48,64,0,0,0,0,0,0},
                   pclr_m:10'h001, done_m:10'h008, ends_idle:1'b1};
        tbl[1] = '{st:1000, sp:1023, stp:100, dw:0, md:0, n:2, vals:'{1000,1023,0,0,0,0,0,0,0,0},
                   pclr_m:10'h001, done_m:10'h002, ends_idle:1'b1};
        tbl[2] = '{st:128, sp:384, stp:128, dw:0, md:2, n:9, vals:'{128,256,384,256,128,256,384,256,128,0},
                   pclr_m:10'h001, done_m:10'h110, ends_idle:1'b0};
        tbl[3] = '{st:0, sp:200, stp:100, dw:1, md:1, n:6, vals:'{0,100,200,0,100,200,0,0,0,0},
                   pclr_m:10'h009, done_m:10'h024, ends_idle:1'b0};
        tbl[4] = '{st:5, sp:8, stp:0, dw:0, md:3, n:4, vals:'{5,6,7,8,0,0,0,0,0,0},
                   pclr_m:10'h001, done_m:10'h008, ends_idle:1'b1};
        tbl[5] = '{st:50, sp:50, stp:3, dw:1, md:1, n:3, vals:'{50,50,50,0,0,0,0,0,0,0},
                   pclr_m:10'h007, done_m:10'h007, ends_idle:1'b0};
        tbl[6] = '{st:0, sp:10, stp:7, dw:0, md:2, n:7, vals:'{0,7,10,3,0,7,10,0,0,0},
                   pclr_m:10'h001, done_m:10'h010, ends_idle:1'b0};

        rst_n = 1'b0; cfg_valid = 1'b0; start = 1'b0; abort = 1'b0;
        set_cfg(0, 0, 0, 0, 0);

        // Reset state, with start asserted to show reset dominates.
        @(posedge clk); #1;
        start = 1'b1;
        push_idle();
        check_pop("reset_state");
        @(posedge clk); #1;
        start = 1'b0; rst_n = 1'b1;

        // Table: config offered in the same cycle as start.
        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1;
            set_cfg(tbl[i].st, tbl[i].sp, tbl[i].stp, tbl[i].dw, tbl[i].md);
            cfg_valid = 1'b1; start = 1'b1;
            push_vec(tbl[i]);
            @(posedge clk); #1;
            cfg_valid = 1'b0; start = 1'b0;
            set_cfg($urandom_range(1023), $urandom_range(1023), $urandom_range(1023), $urandom_range(9), $urandom_range(3));
            drain(tbl[i].ends_idle ? 0 : 1, $sformatf("vec%0d", i));
        end

        // Config accepted alone in IDLE, then busy ignores cfg_valid and start.
        @(posedge clk); #1;
        set_cfg(16, 64, 16, 0, 0); cfg_valid = 1'b1;
        push_idle();
        check_pop("cfg_alone_idle");
        @(posedge clk); #1;
        cfg_valid = 1'b0; start = 1'b1;
        push_rec(16, 1'b1, 1'b0); push_rec(32, 1'b0, 1'b0);
        push_rec(48, 1'b0, 1'b0); push_rec(64, 1'b0, 1'b1); push_idle();
        @(posedge clk); #1;
        set_cfg(500, 600, 50, 5, 1); cfg_valid = 1'b1; start = 1'b1;
        repeat (3) begin
            check_pop("busy_ignore");
            @(posedge clk); #1;
        end
        cfg_valid = 1'b0; start = 1'b0;
        drain(0, "busy_ignore");
        @(posedge clk); #1;
        start = 1'b1;
        push_rec(16, 1'b1, 1'b0); push_rec(32, 1'b0, 1'b0);
        push_rec(48, 1'b0, 1'b0); push_rec(64, 1'b0, 1'b1); push_idle();
        @(posedge clk); #1;
        start = 1'b0;
        drain(0, "cfg_retained");

        // Abort mid-sweep while fcw=32.
        @(posedge clk); #1;
        set_cfg(16, 64, 16, 2, 0); cfg_valid = 1'b1; start = 1'b1;
        repeat (3) push_rec(16, 1'b0, 1'b0);
        sb[0].pclr = 1'b1;
        push_rec(32, 1'b0, 1'b0); push_idle();
        @(posedge clk); #1;
        cfg_valid = 1'b0; start = 1'b0;
        drain(1, "abort_mid");

        // Reset mid-sweep while fcw=32, then config reads back as zeros.
        @(posedge clk); #1;
        start = 1'b1;
        repeat (3) push_rec(16, 1'b0, 1'b0);
        sb[0].pclr = 1'b1;
        push_rec(32, 1'b0, 1'b0); push_idle();
        @(posedge clk); #1;
        start = 1'b0;
        drain(2, "reset_mid");
        @(posedge clk); #1;
        start = 1'b1;
        push_rec(0, 1'b1, 1'b1); push_idle();
        @(posedge clk); #1;
        start = 1'b0;
        drain(0, "zero_cfg");

        // start and abort in the same IDLE cycle: stays idle.
        @(posedge clk); #1;
        set_cfg(16, 64, 16, 0, 0); start = 1'b1; abort = 1'b1;
        push_idle(); push_idle();
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        drain(0, "start_abort");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Absolute time limit so the bench always terminates.
    initial begin
        #5000000;
        $display("FAIL timeout: simulation time limit reached, %0d/%0d so far", n_pass, n_checks);
        $fatal(1);
    end

endmodule

// File: doc/dds_sweep_controller.md
# dds_sweep_controller

Frequency-sweep sequencer for the DDS phase accumulator. Accepts a sweep configuration over a valid/ready handshake and drives the accumulator's frequency control word (FCW) through a programmed ramp, holding each FCW value for a programmable dwell time. It issues a phase-clear pulse at each sweep restart and reports completion. It sits between the register/control logic and the phase accumulator + phase-to-amplitude path.

## Interface
- `FCW_W`, 10: FCW width; matches the accumulator phase width.
- `DWELL_W`, 16: dwell counter width.
- `clk`  in  1  system clock (1 MHz)
- `rst_n`  in  1  synchronous, active-low reset
- `cfg_valid`  in  1  configuration offer
- `cfg_ready`  out  1  config accepted when `cfg_valid && cfg_ready`
- `cfg_fcw_start`  in  FCW_W  first FCW of the sweep
- `cfg_fcw_stop`  in  FCW_W  final/turn-around FCW
- `cfg_fcw_step`  in  FCW_W  increment per step; 0 is treated as 1
- `cfg_dwell`  in  DWELL_W  each FCW is held for `cfg_dwell+1` cycles
- `cfg_mode`  in  2  0 = up one-shot, 1 = up repeat, 2 = triangle repeat, 3 = reserved (behaves as 0)
- `start`  in  1  begin a sweep (level-sampled)
- `abort`  in  1  stop immediately
- `busy`  out  1  sweep in progress
- `fcw`  out  FCW_W  FCW to the accumulator
- `fcw_valid`  out  1  `fcw` is live
- `phase_clr`  out  1  one-cycle accumulator phase clear
- `sweep_done`  out  1  one-cycle pulse at the end of each sweep period

## Operation
- States:
  - IDLE: `cfg_ready=1`.
  - LOAD: one cycle.
  - DWELL: counting.
  - STEP: one-cycle compute, folded into the last DWELL cycle.
- IDLE → LOAD on `start && !abort`. LOAD → DWELL. DWELL → IDLE on the final completion of mode 0/3. Any state → IDLE on `abort` (next cycle).
- Config capture:
  - Registers load only in IDLE on `cfg_valid`.
  - If `cfg_valid` and `start` arrive in the same cycle, the new config is used.
  - Reset config is all zeros (mode 0, FCW 0).
- LOAD: `fcw<=start`, `phase_clr=1`, `fcw_valid=1`, direction = up, dwell counter loaded.
- Step arithmetic (FCW_W+1 bits, no wrap):
  - Up: `next = fcw + step`. If `next >= stop` or the result carries out, `fcw<=stop` and the up leg ends.
  - Down: `next = fcw - step`. If `next <= start` or the result borrows, `fcw<=start` and the down leg ends.
- If `start >= stop`: single-point sweep. `fcw` holds `start`, and each dwell ends a period.
- End of period:
  - Mode 0/3: the stop value's dwell finishes → `sweep_done`, then IDLE.
  - Mode 1: the stop value's dwell finishes → `sweep_done`, `fcw<=start`, `phase_clr` pulse.
  - Mode 2: at the stop value, reverse direction (no `phase_clr`). When the start value's dwell on the down leg finishes → `sweep_done`, then the up leg restarts from `start+step`.
- `start` while busy: ignored. `cfg_valid` while busy: not accepted (`cfg_ready=0`).
- `abort` and `start` in the same IDLE cycle: abort wins, `start` is ignored.

## Timing
- Reset values (synchronous, with `rst_n` low at a clock edge):
  - state IDLE
  - `cfg_ready=1`
  - `busy=0`, `fcw=0`, `fcw_valid=0`, `phase_clr=0`, `sweep_done=0`
  - dwell counter 0
- Reset mid-sweep: the same values apply, and the config registers are cleared.
- `start` sampled at edge N → LOAD outputs (`fcw`, `phase_clr`, `busy`) visible after edge N+1.
- Each FCW value is held for exactly `dwell+1` cycles. The new value appears on the edge that ends the previous dwell, with no gap cycles.
- `sweep_done` is asserted in the last cycle of the final dwell of a period. In mode 0, `busy` and `fcw_valid` drop the following cycle, and `fcw` returns to 0.
- Abort at edge N → IDLE outputs after edge N+1. No `sweep_done` is issued.
- All outputs are registered except `cfg_ready`, which is decoded from the state register.

## Structure
- Shared package `dds_pkg`:
  - mode encodings (`MODE_UP_ONESHOT`, `MODE_UP_REPEAT`, `MODE_TRIANGLE`)
  - state enum
  - default `FCW_W` and `DWELL_W`
- Sub-module `dwell_timer`: loadable down-counter with `load`, `load_val`, `expire` (asserted when the count is 0).
- Everything else (FSM, step datapath) lives in the top module.

## Test plan
- Basic one-shot (mode 0), cfg start=16, stop=64, step=16, dwell=2; `start` at cycle 0:
  - `fcw` = 16 (cycles 1-3), 32 (4-6), 48 (7-9), 64 (10-12)
  - `phase_clr` at cycle 1 only
  - `sweep_done` at cycle 12; `busy=0` and `fcw=0` at cycle 13.
- Overflow clamp, start=1000, stop=1023, step=100, dwell=0, mode 0 → `fcw` 1000, 1023, then `sweep_done`. No wrap to a small value.
- Triangle (mode 2), start=128, stop=384, step=128, dwell=0:
  - `fcw` 128, 256, 384, 256, 128, 256, …
  - `sweep_done` on each 128 of the down leg; `phase_clr` only at LOAD.
- Up repeat (mode 1), start=0, stop=200, step=100, dwell=1 → `fcw` 0, 0, 100, 100, 200, 200, 0, … with `phase_clr` and `sweep_done` on each wrap to 0.
- Abort/reset mid-sweep at `fcw=32`:
  - Next cycle: `busy=0`, `fcw_valid=0`, `fcw=0`, no `sweep_done`.
  - A repeat with `rst_n=0` gives the same outputs, and config reads back as zeros (`start` then yields a constant `fcw=0` one-shot).
- Handshake edge cases:
  - `cfg_valid` while busy is not accepted.
  - `cfg_valid` and `start` in the same cycle: the sweep uses the new config.
  - `start` and `abort` in the same IDLE cycle: the block stays IDLE.
  - step=0 behaves as step=1.
